pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Instruction-fetch stage feeding IMEM and the decode stage. Owns the PC register, next-PC selection
//  (sequential, redirect, stall, halt) and the IF/ID pipeline register. Presents pc to IMEM each cycle;
//  IMEM returns the instruction word within that cycle, and it is captured into IF/ID at the next posedge.
//  Detects misaligned or out-of-range fetch addresses and halts fetch with a latched fault.
// PARAMETERS
//  PC_WIDTH    32            PC / address width
//  INST_WIDTH  32            instruction width
//  IMEM_DEPTH  1024          IMEM size in bytes; last legal fetch address = IMEM_DEPTH-4
//  RESET_PC    0             PC value after reset
//  NOP_INST    32'h00000013  bubble instruction (addi x0,x0,0)
// PORTS
//  clk             in   1           clock, all state on posedge
//  reset           in   1           synchronous, active-high reset
//  stall           in   1           hazard unit: hold PC and IF/ID
//  redirect_valid  in   1           EX: taken branch/jump this cycle
//  redirect_pc     in   PC_WIDTH    EX: branch/jump target
//  halt_req        in   1           stop fetching (ecall/ebreak)
//  imem_inst       in   INST_WIDTH  IMEM read data for current pc
//  pc              out  PC_WIDTH    fetch address to IMEM
//  if_id_valid     out  1           IF/ID holds a real instruction
//  if_id_pc        out  PC_WIDTH    PC of IF/ID instruction
//  if_id_pc_plus4  out  PC_WIDTH    if_id_pc + 4 (link value)
//  if_id_inst      out  INST_WIDTH  instruction to decode
//  fetch_halted    out  1           FSM in HALT
//  fault           out  1           sticky fetch fault
//  fault_cause     out  2           2'b01 misaligned, 2'b10 out of range, 2'b00 none
//  fault_pc        out  PC_WIDTH    offending address
//  fetch_count     out  32          valid instructions captured into IF/ID
// BEHAVIOUR
//  Reset (sync, posedge with reset=1): pc=RESET_PC, if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0,
//   if_id_pc_plus4=0, fault=0, fault_cause=0, fault_pc=0, fetch_count=0, state=RUN. Reset beats all inputs.
//  FSM: RUN, HALT. HALT exits only via reset. fetch_halted = (state==HALT).
//  RUN, per posedge, strict priority:
//   1 redirect_valid: IF/ID <= bubble (valid=0, inst=NOP_INST, pc/pc_plus4 held); stall ignored.
//     redirect_pc[1:0]!=0      -> fault=1, cause=01, fault_pc=redirect_pc, pc held, ->HALT.
//     redirect_pc>IMEM_DEPTH-4 -> fault=1, cause=10, fault_pc=redirect_pc, pc held, ->HALT.
//     else pc<=redirect_pc. Wrong-path word in imem_inst this cycle is discarded.
//   2 halt_req: IF/ID <= bubble, pc held, ->HALT; no fault.
//   3 stall: pc, IF/ID, fetch_count all hold.
//   4 advance: IF/ID <= {1, pc, pc+4, imem_inst}; fetch_count+1.
//     pc+4 > IMEM_DEPTH-4 -> pc held, fault=1, cause=10, fault_pc=pc+4, ->HALT (current inst stays valid).
//     else pc<=pc+4.
//  HALT: pc and fault regs hold; if_id_valid forced 0, if_id_inst=NOP_INST; all inputs ignored.
//  Fetch-to-decode latency: 1 cycle (pc presented cycle n -> if_id_* valid after posedge ending n).
//  Redirect penalty: 1 bubble. Arithmetic: pc+4 mod 2^PC_WIDTH; fetch_count wraps mod 2^32.
//  Range compares unsigned at PC_WIDTH. Fault regs written once; first fault wins.
// STRUCTURE
//  Shared defines (risc_v_defines.vh): NOP_INST value, FAULT_MISALIGN/FAULT_RANGE codes,
//   FETCH_RUN/FETCH_HALT encodings; PC_WIDTH/INST_WIDTH/IMEM_DEPTH defaults already there.
//  Sub-module if_id_reg: load / bubble / hold controls, sync reset; fetch FSM + next-PC logic in top.
//  System top ties IMEM reset_n = ~reset.
// TESTING
//  1 Reset 3 cycles, release, no stall, IMEM words W0..W3 at 0,4,8,12 -> if_id (pc,inst) = (0,W0),(4,W1),
//    (8,W2) on consecutive cycles; fetch_count=3.
//  2 Stall 2 cycles with pc=8 -> pc=8 and if_id=(4,W1) hold both cycles; fetch_count unchanged.
//  3 redirect_valid+stall, redirect_pc=0x40 at pc=12 -> next cycle pc=0x40, if_id_valid=0, inst=NOP;
//    following cycle if_id=(0x40,W@0x40).
//  4 redirect_pc=0x42 -> fault=1, cause=01, fault_pc=0x42, fetch_halted=1; later redirects/stalls no effect.
//  5 Sequential run to pc=IMEM_DEPTH-4 -> that inst captured valid, fault cause=10, fault_pc=IMEM_DEPTH,
//    HALT; reset mid-HALT -> pc=RESET_PC, fault=0, fetch_count=0.
//  6 halt_req at pc=8 -> HALT, fault=0, if_id_valid=0; assert reset with stall=1 -> reset wins.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pc_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: bubble beats load; with neither asserted it holds.
module pc_fetch_unit_if_id_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_WIDTH   = 32,
    parameter int          INST_WIDTH = 32,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  bubble,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    input  logic [PC_WIDTH-1:0]   fetch_pc_plus4,
    input  logic [INST_WIDTH-1:0] fetch_inst,
    output logic                  valid,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_plus4,
    output logic [INST_WIDTH-1:0] inst
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            pc       <= '0;
            pc_plus4 <= '0;
            inst     <= INST_WIDTH'(NOP_INST);
        end else if (bubble) begin
            // Bubble keeps the last pc/pc_plus4 so decode sees a stable link value.
            valid <= 1'b0;
            inst  <= INST_WIDTH'(NOP_INST);
        end else if (load) begin
            valid    <= 1'b1;
            pc       <= fetch_pc;
            pc_plus4 <= fetch_pc_plus4;
            inst     <= fetch_inst;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: PC register, next-PC selection, RUN/HALT FSM with sticky fault, IF/ID register.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int                 PC_WIDTH   = 32,
    parameter int                 INST_WIDTH = 32,
    parameter int                 IMEM_DEPTH = 1024,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]        NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    input  logic                  halt_req,
    input  logic [INST_WIDTH-1:0] imem_inst,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  if_id_valid,
    output logic [PC_WIDTH-1:0]   if_id_pc,
    output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
    output logic [INST_WIDTH-1:0] if_id_inst,
    output logic                  fetch_halted,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [PC_WIDTH-1:0]   fault_pc,
    output logic [31:0]           fetch_count
);

    localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(IMEM_DEPTH - 4);

    fetch_state_t        state;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                running;
    logic                if_id_load;
    logic                if_id_bubble;

    assign pc_plus4     = pc + PC_WIDTH'(4);
    assign running      = (state == FETCH_RUN);
    assign fetch_halted = (state == FETCH_HALT);

    // HALT forces a bubble every cycle; redirect and halt_req bubble regardless of stall.
    assign if_id_bubble = !running || redirect_valid || halt_req;
    assign if_id_load   = running && !redirect_valid && !halt_req && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH_RUN;
            pc          <= RESET_PC;
            fault       <= 1'b0;
            fault_cause <= FAULT_NONE;
            fault_pc    <= '0;
            fetch_count <= '0;
        end else if (state == FETCH_RUN) begin
            if (redirect_valid) begin
                if (redirect_pc[1:0] != 2'b00) begin
                    fault       <= 1'b1;
                    fault_cause <= FAULT_MISALIGN;
                    fault_pc    <= redirect_pc;
                    state       <= FETCH_HALT;
                end else if (redirect_pc > LAST_PC) begin
                    fault       <= 1'b1;
                    fault_cause <= FAULT_RANGE;
                    fault_pc    <= redirect_pc;
                    state       <= FETCH_HALT;
                end else begin
                    pc <= redirect_pc;
                end
            end else if (halt_req) begin
                state <= FETCH_HALT;
            end else if (!stall) begin
                fetch_count <= fetch_count + 32'd1;
                // The word at the last legal address is still delivered before halting.
                if (pc_plus4 > LAST_PC) begin
                    fault       <= 1'b1;
                    fault_cause <= FAULT_RANGE;
                    fault_pc    <= pc_plus4;
                    state       <= FETCH_HALT;
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

    pc_fetch_unit_if_id_reg #(
        .PC_WIDTH   (PC_WIDTH),
        .INST_WIDTH (INST_WIDTH),
        .NOP_INST   (NOP_INST)
    ) u_if_id_reg (
        .clk            (clk),
        .reset          (reset),
        .load           (if_id_load),
        .bubble         (if_id_bubble),
        .fetch_pc       (pc),
        .fetch_pc_plus4 (pc_plus4),
        .fetch_inst     (imem_inst),
        .valid          (if_id_valid),
        .pc             (if_id_pc),
        .pc_plus4       (if_id_pc_plus4),
        .inst           (if_id_inst)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural IMEM and an IF/ID expectation queue.
module tb_pc_fetch_unit;

    localparam int          PC_W  = 32;
    localparam int          INST_W = 32;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              halt_req;
    logic [INST_W-1:0] imem_inst;
    logic [PC_W-1:0]   pc;
    logic              if_id_valid;
    logic [PC_W-1:0]   if_id_pc;
    logic [PC_W-1:0]   if_id_pc_plus4;
    logic [INST_W-1:0] if_id_inst;
    logic              fetch_halted;
    logic              fault;
    logic [1:0]        fault_cause;
    logic [PC_W-1:0]   fault_pc;
    logic [31:0]       fetch_count;

    int compared   = 0;
    int mismatched = 0;

    // Expected IF/ID contents: {valid, pc, pc_plus4, inst}
    logic [96:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'hA500_0000 ^ addr;
    endfunction

    // IMEM responds combinationally to the presented pc.
    assign imem_inst = word_at(pc);

    pc_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .imem_inst      (imem_inst),
        .pc             (pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_inst     (if_id_inst),
        .fetch_halted   (fetch_halted),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if_id(input logic v, input logic [31:0] p, input logic [31:0] p4,
                              input logic [31:0] ins);
        exp_q.push_back({v, p, p4, ins});
    endtask

    task automatic pop_if_id(input string tag);
        logic [96:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 97'd1, 97'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {if_id_valid, if_id_pc, if_id_pc_plus4, if_id_inst}, e);
        end
    endtask

    // Advance one cycle with no control asserted, expecting the current pc to be captured.
    task automatic fetch_one(input string tag);
        logic [31:0] p;
        p = pc;
        push_if_id(1'b1, p, p + 32'd4, word_at(p));
        step();
        pop_if_id(tag);
    endtask

    initial begin
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        repeat (3) step();

        check("rst_pc",     97'(pc), 97'd0);
        check("rst_if_id",  {if_id_valid, if_id_pc, if_id_pc_plus4, if_id_inst},
              {1'b0, 32'd0, 32'd0, NOP});
        check("rst_fault",  {fault, fault_cause, fault_pc}, 97'd0);
        check("rst_count",  97'(fetch_count), 97'd0);
        check("rst_halted", 97'(fetch_halted), 97'd0);

        // Sequential fetch: (0,W0), (4,W1)
        reset = 1'b0;
        fetch_one("seq0");
        fetch_one("seq1");
        check("seq_pc", 97'(pc), 97'd8);

        // Stall two cycles at pc=8: everything holds
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_if_id(1'b1, 32'd4, 32'd8, word_at(32'd4));
            step();
            pop_if_id("stall_if_id");
            check("stall_pc", 97'(pc), 97'd8);
            check("stall_count", 97'(fetch_count), 97'd2);
        end
        stall = 1'b0;
        fetch_one("seq2");
        check("seq_count", 97'(fetch_count), 97'd3);
        check("seq_pc12", 97'(pc), 97'd12);

        // Redirect with stall at pc=12: redirect wins, one bubble
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        push_if_id(1'b0, 32'd8, 32'd12, NOP);
        step();
        pop_if_id("redir_bubble");
        check("redir_pc", 97'(pc), 97'h40);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        fetch_one("redir_target");
        check("redir_count", 97'(fetch_count), 97'd4);

        // Misaligned redirect faults and halts; later inputs are ignored
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        check("mis_fault", {fault, fault_cause, fault_pc}, {1'b1, 2'b01, 32'h42});
        check("mis_halted", 97'(fetch_halted), 97'd1);
        check("mis_pc", 97'(pc), 97'h44);
        check("mis_valid", {if_id_valid, if_id_inst}, {1'b0, NOP});
        redirect_pc = 32'h80;
        stall       = 1'b1;
        halt_req    = 1'b1;
        repeat (2) step();
        check("halt_ign_pc", 97'(pc), 97'h44);
        check("halt_ign_fault", {fault, fault_cause, fault_pc}, {1'b1, 2'b01, 32'h42});
        check("halt_ign_count", 97'(fetch_count), 97'd4);
        check("halt_ign_valid", {if_id_valid, if_id_pc, if_id_inst}, {1'b0, 32'h40, NOP});
        redirect_valid = 1'b0;
        stall          = 1'b0;
        halt_req       = 1'b0;

        // Reset, then run sequentially to the end of IMEM
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < DEPTH / 4; i++) begin
            fetch_one("run_seq");
        end
        check("end_fault", {fault, fault_cause, fault_pc}, {1'b1, 2'b10, 32'(DEPTH)});
        check("end_halted", 97'(fetch_halted), 97'd1);
        check("end_pc", 97'(pc), 97'(DEPTH - 4));
        check("end_count", 97'(fetch_count), 97'(DEPTH / 4));
        push_if_id(1'b0, 32'(DEPTH - 4), 32'(DEPTH), NOP);
        step();
        pop_if_id("end_bubble");

        // Reset out of HALT
        reset = 1'b1;
        step();
        check("rst2_pc", 97'(pc), 97'd0);
        check("rst2_fault", {fault, fault_cause, fault_pc}, 97'd0);
        check("rst2_count", 97'(fetch_count), 97'd0);
        check("rst2_halted", 97'(fetch_halted), 97'd0);
        reset = 1'b0;

        // halt_req at pc=8: clean halt without fault
        fetch_one("hr_seq0");
        fetch_one("hr_seq1");
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        check("hr_halted", 97'(fetch_halted), 97'd1);
        check("hr_fault", 97'(fault), 97'd0);
        check("hr_pc", 97'(pc), 97'd8);
        check("hr_valid", {if_id_valid, if_id_inst}, {1'b0, NOP});
        step();
        check("hr_still_halted", 97'(fetch_halted), 97'd1);

        // Reset together with stall: reset wins and fetch resumes from RESET_PC
        reset = 1'b1;
        stall = 1'b1;
        step();
        check("rs_pc", 97'(pc), 97'd0);
        check("rs_halted", 97'(fetch_halted), 97'd0);
        check("rs_if_id", {if_id_valid, if_id_pc, if_id_pc_plus4, if_id_inst},
              {1'b0, 32'd0, 32'd0, NOP});
        reset = 1'b0;
        stall = 1'b0;
        fetch_one("rs_resume");
        check("rs_count", 97'(fetch_count), 97'd1);

        check("queue_drained", 97'(exp_q.size()), 97'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
